dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Two-requester arbiter and access sequencer in front of the data memory. It accepts load/store requests from the core load/store path (port 0) and a debug/DMA path (port 1), grants one at a time, and drives the memory's single-cycle enable/byte-select interface. It absorbs the memory's one-cycle registered read latency and returns each response on the requester's own valid/ready channel. It flags accesses that fall outside the RAM window or the two read-only ID words.

## Interface
- `RAM_BASE`, default 32'h8000_0000: first byte address of the RAM window.
- `RAM_BYTES`, default 4096: RAM window size in bytes.
- `ROM_ADDR0` / `ROM_ADDR1`, default 32'h0010_0000 / 32'h0010_0004: read-only ID word addresses.
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `reqNValid` in 1 (N=0,1): request present.
- `reqNReady` out 1: request accepted this cycle.
- `reqNWrite` in 1: 1=store, 0=load.
- `reqNAddr` in 32: byte address.
- `reqNWData` in 32: store data.
- `reqNByteSel` in 4: byte lanes.
- `reqNLoadSel` in 3: load type, passed through to memory.
- `rspNValid` out 1: response present.
- `rspNReady` in 1: requester takes response.
- `rspNRData` out 32: load data (0 for stores).
- `rspNErr` out 1: access outside legal windows.
- `memReadEnable`, `memWriteEnable` out 1: memory strobes.
- `memAddress`, `memDataIn` out 32; `memReadByteSelect`, `memWriteByteSelect` out 4; `memLoadSelect` out 3.
- `memDataOut` in 32: memory read data, registered inside memory.

## Operation
- Single outstanding access. FSM: IDLE -> ACCESS -> LATCH -> RESP -> IDLE.
- IDLE: if any `reqNValid`, pick a winner and pulse its `reqNReady` for one cycle. Latch write, address, write data, byte select, load select, grant id and error flag. Go to ACCESS. Both ready signals are low in every other state.
- Legal read: address in [RAM_BASE, RAM_BASE+RAM_BYTES), or equal to ROM_ADDR0 or ROM_ADDR1. Legal write: RAM window only.
- ACCESS: drive latched fields to the memory ports for exactly one cycle.
  - Load: `memReadEnable`=1.
  - Legal store: `memWriteEnable`=1 with `memWriteByteSelect`=latched select.
  - Illegal store: `memWriteEnable` stays 0 (suppressed).
  - Illegal load is still issued; the memory returns 32'hDEAD_BEEF and that value is passed through.
- Strobes and byte selects are 0 outside ACCESS. Address and data outputs hold their last value.
- LATCH: capture `memDataOut` into the response data register for loads; load 0 for stores. Go to RESP.
- RESP: assert the granted port's `rspNValid`, `rspNRData` and `rspNErr`. Hold them stable until `rspNReady`=1. On that edge go to IDLE, clearing valid. The non-granted port's response outputs stay 0.
- Arbitration is fixed priority or round-robin; see Configuration.
- Requests arriving outside IDLE wait. Requesters hold valid and fields until ready.

## Timing
- Reset: state IDLE, all `reqNReady`/`rspNValid`/`rspNErr`=0, `rspNRData`=0, all `mem*` outputs=0, round-robin pointer=0.
- Accept at cycle T (ready high) -> memory strobe at T+1 -> capture at T+2 -> `rspNValid` first high at T+3.
- With `rspNReady` already high, the response lasts one cycle. The next accept is possible at T+4, giving a minimum of 4 cycles per access.
- `rst` mid-access drops the access. A store in ACCESS is not guaranteed.
- `rst` in RESP discards the response; the requester must reissue.
- Simultaneous valids in IDLE resolve in the same cycle. Exactly one ready is ever high.

## Configuration
- `DMEM_ARB_ROUND_ROBIN_EN` defined: a 1-bit pointer names the preferred port. On each grant the pointer is set to the other port. With both valid continuously, grants alternate 0,1,0,1.
- Not defined: fixed priority, port 0 always wins. Port 1 is granted only in IDLE cycles where `req0Valid`=0. No pointer register.

## Test plan
- Port 0 store 32'hCAFE_F00D to 0x8000_0010 with byteSel 4'hF, then load the same address. Required: load `rsp0RData`=32'hCAFE_F00D, `rsp0Err`=0, `rsp0Valid` 3 cycles after accept.
- Port 1 load from 0x0010_0004. Required: `rsp1RData`=10452084, `rsp1Err`=0.
- Port 0 store to 0x0010_0000, then load 0x0010_0000. Required:
  - store: `rsp0Err`=1 and `memWriteEnable` never high;
  - load: returns 10338916 (ROM unchanged).
- Load from 0x9000_0000. Required: `rspNRData`=32'hDEAD_BEEF, `rspNErr`=1.
- Both ports valid continuously for 4 accesses. Required:
  - round-robin build: grants 0,1,0,1;
  - fixed build: grants 0,0,0,0.
- Hold `rsp0Ready`=0 for 5 cycles in RESP, then assert `rst`. Required:
  - valid and data stay stable while ready is low;
  - after reset, all outputs are 0 and the state is IDLE.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: two-requester arbiter and access sequencer for the data memory.
//
// Port 0 (core load/store path) and port 1 (debug/DMA path) each present a
// valid/ready request channel and a valid/ready response channel. One access is
// in flight at a time: IDLE -> ACCESS -> LATCH -> RESP -> IDLE. The memory has a
// one-cycle registered read, so read data is captured one cycle after the strobe.
// Accesses outside the RAM window (or stores to the ID words) are flagged in rspNErr.
// Illegal stores are suppressed at the memory.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   reqN{Valid,Ready,Write,Addr,WData,ByteSel,LoadSel}   request channel, N = 0/1
//   rspN{Valid,Ready,RData,Err}    response channel, N = 0/1
//   mem{Read,Write}Enable, memAddress, memDataIn, mem{Read,Write}ByteSelect,
//   memLoadSelect                  memory request side (registered)
//   memDataOut                     memory read data (registered inside memory)
//
// Optional feature: define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise port 0 has fixed priority.
module dmem_port_arbiter #(
    parameter logic [31:0] RAM_BASE  = 32'h8000_0000,
    parameter int unsigned RAM_BYTES = 4096,
    parameter logic [31:0] ROM_ADDR0 = 32'h0010_0000,
    parameter logic [31:0] ROM_ADDR1 = 32'h0010_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0Valid,
    output logic        req0Ready,
    input  logic        req0Write,
    input  logic [31:0] req0Addr,
    input  logic [31:0] req0WData,
    input  logic [3:0]  req0ByteSel,
    input  logic [2:0]  req0LoadSel,
    output logic        rsp0Valid,
    input  logic        rsp0Ready,
    output logic [31:0] rsp0RData,
    output logic        rsp0Err,
    input  logic        req1Valid,
    output logic        req1Ready,
    input  logic        req1Write,
    input  logic [31:0] req1Addr,
    input  logic [31:0] req1WData,
    input  logic [3:0]  req1ByteSel,
    input  logic [2:0]  req1LoadSel,
    output logic        rsp1Valid,
    input  logic        rsp1Ready,
    output logic [31:0] rsp1RData,
    output logic        rsp1Err,
    output logic        memReadEnable,
    output logic        memWriteEnable,
    output logic [31:0] memAddress,
    output logic [31:0] memDataIn,
    output logic [3:0]  memReadByteSelect,
    output logic [3:0]  memWriteByteSelect,
    output logic [2:0]  memLoadSelect,
    input  logic [31:0] memDataOut
);

    typedef enum logic [1:0] {StIdle, StAccess, StLatch, StResp} state_e;

    state_e      state_q;
    logic        grant_q;
    logic        write_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        grant_sel;
    logic        sel_write;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_bsel;
    logic [2:0]  sel_lsel;
    logic        in_ram;
    logic        in_rom;
    logic        sel_err;
    logic        accept;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic ptr_q;  // preferred port when both request

    always_comb begin
        grant_sel = req1Valid;
        if (req0Valid && req1Valid) begin
            grant_sel = ptr_q;
        end
    end
`else
    always_comb begin
        grant_sel = ~req0Valid;
    end
`endif

    always_comb begin
        sel_write = grant_sel ? req1Write   : req0Write;
        sel_addr  = grant_sel ? req1Addr    : req0Addr;
        sel_wdata = grant_sel ? req1WData   : req0WData;
        sel_bsel  = grant_sel ? req1ByteSel : req0ByteSel;
        sel_lsel  = grant_sel ? req1LoadSel : req0LoadSel;
        // Offset compare avoids overflow at the top of the address space.
        in_ram    = (sel_addr >= RAM_BASE) && ((sel_addr - RAM_BASE) < 32'(RAM_BYTES));
        in_rom    = (sel_addr == ROM_ADDR0) || (sel_addr == ROM_ADDR1);
        sel_err   = sel_write ? ~in_ram : ~(in_ram | in_rom);
        accept    = (state_q == StIdle) && (req0Valid || req1Valid) && !rst;
    end

    // Ready is combinational so the handshake completes in the arbitration cycle.
    assign req0Ready = accept & ~grant_sel;
    assign req1Ready = accept &  grant_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= StIdle;
            grant_q            <= 1'b0;
            write_q            <= 1'b0;
            err_q              <= 1'b0;
            rdata_q            <= 32'h0;
            memReadEnable      <= 1'b0;
            memWriteEnable     <= 1'b0;
            memAddress         <= 32'h0;
            memDataIn          <= 32'h0;
            memReadByteSelect  <= 4'h0;
            memWriteByteSelect <= 4'h0;
            memLoadSelect      <= 3'h0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            ptr_q              <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        grant_q            <= grant_sel;
                        write_q            <= sel_write;
                        err_q              <= sel_err;
                        memAddress         <= sel_addr;
                        memDataIn          <= sel_wdata;
                        memLoadSelect      <= sel_lsel;
                        // Illegal loads still go out; illegal stores are suppressed.
                        memReadEnable      <= ~sel_write;
                        memReadByteSelect  <= sel_write ? 4'h0 : sel_bsel;
                        memWriteEnable     <= sel_write & ~sel_err;
                        memWriteByteSelect <= (sel_write && !sel_err) ? sel_bsel : 4'h0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                        ptr_q              <= ~grant_sel;
`endif
                        state_q            <= StAccess;
                    end
                end
                StAccess: begin
                    memReadEnable      <= 1'b0;
                    memWriteEnable     <= 1'b0;
                    memReadByteSelect  <= 4'h0;
                    memWriteByteSelect <= 4'h0;
                    state_q            <= StLatch;
                end
                StLatch: begin
                    rdata_q <= write_q ? 32'h0 : memDataOut;
                    state_q <= StResp;
                end
                StResp: begin
                    if (grant_q ? rsp1Ready : rsp0Ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Only the granted port sees response values; the other stays at zero.
    always_comb begin
        rsp0Valid = (state_q == StResp) && !grant_q;
        rsp1Valid = (state_q == StResp) &&  grant_q;
        rsp0RData = rsp0Valid ? rdata_q : 32'h0;
        rsp1RData = rsp1Valid ? rdata_q : 32'h0;
        rsp0Err   = rsp0Valid & err_q;
        rsp1Err   = rsp1Valid & err_q;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    localparam logic [31:0] RAM_BASE  = 32'h8000_0000;
    localparam int unsigned RAM_BYTES = 4096;
    localparam logic [31:0] ROM_ADDR0 = 32'h0010_0000;
    localparam logic [31:0] ROM_ADDR1 = 32'h0010_0004;
    localparam logic [31:0] ROM0_VAL  = 32'd10338916;
    localparam logic [31:0] ROM1_VAL  = 32'd10452084;
    localparam logic [31:0] BAD_VAL   = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic        req0Valid, req0Ready, req0Write;
    logic [31:0] req0Addr, req0WData;
    logic [3:0]  req0ByteSel;
    logic [2:0]  req0LoadSel;
    logic        rsp0Valid, rsp0Ready, rsp0Err;
    logic [31:0] rsp0RData;
    logic        req1Valid, req1Ready, req1Write;
    logic [31:0] req1Addr, req1WData;
    logic [3:0]  req1ByteSel;
    logic [2:0]  req1LoadSel;
    logic        rsp1Valid, rsp1Ready, rsp1Err;
    logic [31:0] rsp1RData;
    logic        memReadEnable, memWriteEnable;
    logic [31:0] memAddress, memDataIn, memDataOut;
    logic [3:0]  memReadByteSelect, memWriteByteSelect;
    logic [2:0]  memLoadSelect;

    int compared;
    int mismatched;
    int we_count;

    logic [31:0] mem    [0:1023];
    logic [31:0] shadow [0:1023];

    dmem_port_arbiter #(
        .RAM_BASE (RAM_BASE),
        .RAM_BYTES(RAM_BYTES),
        .ROM_ADDR0(ROM_ADDR0),
        .ROM_ADDR1(ROM_ADDR1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req0Valid         (req0Valid),
        .req0Ready         (req0Ready),
        .req0Write         (req0Write),
        .req0Addr          (req0Addr),
        .req0WData         (req0WData),
        .req0ByteSel       (req0ByteSel),
        .req0LoadSel       (req0LoadSel),
        .rsp0Valid         (rsp0Valid),
        .rsp0Ready         (rsp0Ready),
        .rsp0RData         (rsp0RData),
        .rsp0Err           (rsp0Err),
        .req1Valid         (req1Valid),
        .req1Ready         (req1Ready),
        .req1Write         (req1Write),
        .req1Addr          (req1Addr),
        .req1WData         (req1WData),
        .req1ByteSel       (req1ByteSel),
        .req1LoadSel       (req1LoadSel),
        .rsp1Valid         (rsp1Valid),
        .rsp1Ready         (rsp1Ready),
        .rsp1RData         (rsp1RData),
        .rsp1Err           (rsp1Err),
        .memReadEnable     (memReadEnable),
        .memWriteEnable    (memWriteEnable),
        .memAddress        (memAddress),
        .memDataIn         (memDataIn),
        .memReadByteSelect (memReadByteSelect),
        .memWriteByteSelect(memWriteByteSelect),
        .memLoadSelect     (memLoadSelect),
        .memDataOut        (memDataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit in_ram(input logic [31:0] a);
        longint la;
        la = longint'({32'h0, a});
        return (la >= longint'({32'h0, RAM_BASE})) &&
               (la <  longint'({32'h0, RAM_BASE}) + longint'(RAM_BYTES));
    endfunction

    function automatic int word_idx(input logic [31:0] a);
        return int'((a - RAM_BASE) >> 2);
    endfunction

    // Memory environment: registered read, byte-lane writes, ID words, 0xDEADBEEF elsewhere.
    always @(posedge clk) begin
        if (memWriteEnable) begin
            we_count <= we_count + 1;
            if (in_ram(memAddress)) begin
                for (int b = 0; b < 4; b++) begin
                    if (memWriteByteSelect[b]) begin
                        mem[word_idx(memAddress)][8*b +: 8] <= memDataIn[8*b +: 8];
                    end
                end
            end
        end
        if (memReadEnable) begin
            if (in_ram(memAddress))            memDataOut <= mem[word_idx(memAddress)];
            else if (memAddress == ROM_ADDR0)  memDataOut <= ROM0_VAL;
            else if (memAddress == ROM_ADDR1)  memDataOut <= ROM1_VAL;
            else                               memDataOut <= BAD_VAL;
        end
    end

    // Reference: what a requester should observe for one access.
    function automatic void ref_access(input logic wr, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] bsel,
                                       output logic [31:0] rdata, output logic err);
        if (wr) begin
            rdata = 32'h0;
            err   = !in_ram(addr);
            if (!err) begin
                for (int b = 0; b < 4; b++) begin
                    if (bsel[b]) shadow[word_idx(addr)][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end else if (in_ram(addr)) begin
            rdata = shadow[word_idx(addr)];
            err   = 1'b0;
        end else if (addr == ROM_ADDR0) begin
            rdata = ROM0_VAL;
            err   = 1'b0;
        end else if (addr == ROM_ADDR1) begin
            rdata = ROM1_VAL;
            err   = 1'b0;
        end else begin
            rdata = BAD_VAL;
            err   = 1'b1;
        end
    endfunction

    // Drives one access on a port with response ready held high; lat = -1 on timeout.
    task automatic run_access(input int port, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] bsel,
                              output logic [31:0] rdata, output logic err, output int lat,
                              output logic other_quiet);
        bit got;
        rdata       = 32'h0;
        err         = 1'b0;
        lat         = -1;
        other_quiet = 1'b1;
        @(negedge clk);
        if (port == 0) begin
            req0Valid = 1'b1; req0Write = wr; req0Addr = addr; req0WData = wdata;
            req0ByteSel = bsel; req0LoadSel = 3'($urandom_range(0, 7)); rsp0Ready = 1'b1;
        end else begin
            req1Valid = 1'b1; req1Write = wr; req1Addr = addr; req1WData = wdata;
            req1ByteSel = bsel; req1LoadSel = 3'($urandom_range(0, 7)); rsp1Ready = 1'b1;
        end
        got = 0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if ((port == 0) ? req0Ready : req1Ready) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if ((port == 0) ? req1Ready : req0Ready) other_quiet = 1'b0;
        @(posedge clk);
        #1;
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        if (got) begin
            got = 0;
            for (int n = 1; n <= 20; n++) begin
                @(negedge clk);
                if ((port == 0) ? rsp0Valid : rsp1Valid) begin
                    lat   = n;
                    rdata = (port == 0) ? rsp0RData : rsp1RData;
                    err   = (port == 0) ? rsp0Err : rsp1Err;
                    if (port == 0 ? (rsp1Valid || rsp1Err || rsp1RData != 0)
                                  : (rsp0Valid || rsp0Err || rsp0RData != 0)) begin
                        other_quiet = 1'b0;
                    end
                    got = 1;
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        rsp0Ready = 1'b0;
        rsp1Ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0Valid = 1'b0; req1Valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0Valid = 1'b0; req0Write = 1'b0; req0Addr = 32'h0; req0WData = 32'h0;
        req0ByteSel = 4'h0; req0LoadSel = 3'h0; rsp0Ready = 1'b0;
        req1Valid = 1'b0; req1Write = 1'b0; req1Addr = 32'h0; req1WData = 32'h0;
        req1ByteSel = 4'h0; req1LoadSel = 3'h0; rsp1Ready = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({req0Ready, req1Ready, rsp0Valid, rsp1Valid, rsp0Err, rsp1Err} !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_handshake: got %b, required 000000",
                     {req0Ready, req1Ready, rsp0Valid, rsp1Valid, rsp0Err, rsp1Err});
        end
        compared++;
        if ({rsp0RData, rsp1RData} !== 64'h0) begin
            mismatched++;
            $display("FAIL reset_rdata: got %h/%h, required 0/0", rsp0RData, rsp1RData);
        end
        compared++;
        if ({memReadEnable, memWriteEnable, memAddress, memDataIn, memReadByteSelect,
             memWriteByteSelect, memLoadSelect} !== 77'h0) begin
            mismatched++;
            $display("FAIL reset_mem: got re=%b we=%b a=%h d=%h rbs=%h wbs=%h ls=%h, required all 0",
                     memReadEnable, memWriteEnable, memAddress, memDataIn, memReadByteSelect,
                     memWriteByteSelect, memLoadSelect);
        end
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        logic [31:0] rd, exp_rd;
        logic        er, exp_er, quiet;
        int          lat, we0;
        we0 = we_count;
        ref_access(1'b1, 32'h8000_0010, 32'hCAFE_F00D, 4'hF, exp_rd, exp_er);
        run_access(0, 1'b1, 32'h8000_0010, 32'hCAFE_F00D, 4'hF, rd, er, lat, quiet);
        compared++;
        if (rd !== 32'h0 || er !== 1'b0 || lat != 3 || we_count != we0 + 1) begin
            mismatched++;
            $display("FAIL store_ram: got rd=%h err=%b lat=%0d writes=%0d, required 0/0/3/1",
                     rd, er, lat, we_count - we0);
        end
        ref_access(1'b0, 32'h8000_0010, 32'h0, 4'hF, exp_rd, exp_er);
        run_access(0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, rd, er, lat, quiet);
        compared++;
        if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin
            mismatched++;
            $display("FAIL load_ram: got rd=%h err=%b, required cafef00d/0", rd, er);
        end
        compared++;
        if (lat != 3 || !quiet) begin
            mismatched++;
            $display("FAIL load_latency: got lat=%0d quiet=%b, required 3/1", lat, quiet);
        end
    endtask

    task automatic test_rom_load();
        logic [31:0] rd, exp_rd;
        logic        er, exp_er, quiet;
        int          lat;
        ref_access(1'b0, ROM_ADDR1, 32'h0, 4'hF, exp_rd, exp_er);
        run_access(1, 1'b0, ROM_ADDR1, 32'h0, 4'hF, rd, er, lat, quiet);
        compared++;
        if (rd !== ROM1_VAL || er !== 1'b0 || lat != 3 || !quiet) begin
            mismatched++;
            $display("FAIL rom1_load: got rd=%0d err=%b lat=%0d quiet=%b, required %0d/0/3/1",
                     rd, er, lat, quiet, ROM1_VAL);
        end
    endtask

    task automatic test_rom_store();
        logic [31:0] rd, exp_rd;
        logic        er, exp_er, quiet;
        int          lat, we0;
        we0 = we_count;
        ref_access(1'b1, ROM_ADDR0, 32'h1234_5678, 4'hF, exp_rd, exp_er);
        run_access(0, 1'b1, ROM_ADDR0, 32'h1234_5678, 4'hF, rd, er, lat, quiet);
        compared++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            mismatched++;
            $display("FAIL rom_store_err: got err=%b rd=%h, required 1/0", er, rd);
        end
        compared++;
        if (we_count != we0) begin
            mismatched++;
            $display("FAIL rom_store_suppress: got %0d write strobes, required 0", we_count - we0);
        end
        run_access(0, 1'b0, ROM_ADDR0, 32'h0, 4'hF, rd, er, lat, quiet);
        compared++;
        if (rd !== ROM0_VAL || er !== 1'b0) begin
            mismatched++;
            $display("FAIL rom0_load: got rd=%0d err=%b, required %0d/0", rd, er, ROM0_VAL);
        end
    endtask

    task automatic test_illegal_load();
        logic [31:0] rd, exp_rd;
        logic        er, exp_er, quiet;
        int          lat;
        ref_access(1'b0, 32'h9000_0000, 32'h0, 4'hF, exp_rd, exp_er);
        run_access(1, 1'b0, 32'h9000_0000, 32'h0, 4'hF, rd, er, lat, quiet);
        compared++;
        if (rd !== BAD_VAL || er !== 1'b1) begin
            mismatched++;
            $display("FAIL illegal_load: got rd=%h err=%b, required deadbeef/1", rd, er);
        end
    endtask

    task automatic test_arbitration();
        int grants[4];
        int cycles[4];
        int exp_g[4];
        int cnt, pref;
        bit both;
        do_reset();
        pref = 0;
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            exp_g[i] = pref;
            pref     = 1 - pref;
`else
            exp_g[i] = 0;
`endif
        end
        @(negedge clk);
        req0Valid = 1'b1; req0Write = 1'b0; req0Addr = RAM_BASE + 32'h40; req0ByteSel = 4'hF;
        req1Valid = 1'b1; req1Write = 1'b0; req1Addr = RAM_BASE + 32'h80; req1ByteSel = 4'hF;
        rsp0Ready = 1'b1; rsp1Ready = 1'b1;
        cnt  = 0;
        both = 0;
        for (int c = 0; c < 40 && cnt < 4; c++) begin
            #1;
            if (req0Ready && req1Ready) both = 1;
            if (req0Ready || req1Ready) begin
                grants[cnt] = req1Ready ? 1 : 0;
                cycles[cnt] = c;
                cnt++;
            end
            @(negedge clk);
        end
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        repeat (6) @(negedge clk);
        rsp0Ready = 1'b0; rsp1Ready = 1'b0;
        compared++;
        if (cnt != 4 || both) begin
            mismatched++;
            $display("FAIL arb_count: got %0d grants dual_ready=%b, required 4/0", cnt, both);
        end
        for (int i = 0; i < cnt; i++) begin
            compared++;
            if (grants[i] != exp_g[i]) begin
                mismatched++;
                $display("FAIL arb_grant%0d: got port %0d, required port %0d", i, grants[i], exp_g[i]);
            end
            if (i > 0) begin
                compared++;
                if (cycles[i] - cycles[i-1] != 4) begin
                    mismatched++;
                    $display("FAIL arb_spacing%0d: got %0d cycles, required 4",
                             i, cycles[i] - cycles[i-1]);
                end
            end
        end
    endtask

    task automatic test_resp_hold_reset();
        logic [31:0] exp_rd, first_rd, rd;
        logic        exp_er, er, quiet, got;
        int          lat;
        ref_access(1'b0, 32'h8000_0010, 32'h0, 4'hF, exp_rd, exp_er);
        @(negedge clk);
        req0Valid = 1'b1; req0Write = 1'b0; req0Addr = 32'h8000_0010; req0ByteSel = 4'hF;
        rsp0Ready = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (req0Ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        req0Valid = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp0Valid) begin
                got = 1'b1;
                break;
            end
        end
        compared++;
        if (!got || rsp0RData !== exp_rd) begin
            mismatched++;
            $display("FAIL hold_first: got valid=%b rd=%h, required 1/%h", got, rsp0RData, exp_rd);
        end
        first_rd = rsp0RData;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compared++;
            if (rsp0Valid !== 1'b1 || rsp0RData !== exp_rd || rsp0Err !== 1'b0) begin
                mismatched++;
                $display("FAIL hold_stable%0d: got valid=%b rd=%h err=%b, required 1/%h/0",
                         i, rsp0Valid, rsp0RData, rsp0Err, exp_rd);
            end
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if ({req0Ready, req1Ready, rsp0Valid, rsp1Valid, rsp0Err, rsp1Err, rsp0RData, rsp1RData,
             memReadEnable, memWriteEnable, memAddress, memDataIn, memReadByteSelect,
             memWriteByteSelect, memLoadSelect} !== 147'h0) begin
            mismatched++;
            $display("FAIL resp_reset: got v0=%b rd0=%h re=%b a=%h d=%h, required all 0",
                     rsp0Valid, rsp0RData, memReadEnable, memAddress, memDataIn);
        end
        @(negedge clk);
        rst = 1'b0;
        // A fresh access with full latency shows the FSM is back in IDLE.
        run_access(1, 1'b0, ROM_ADDR0, 32'h0, 4'hF, rd, er, lat, quiet);
        compared++;
        if (rd !== ROM0_VAL || lat != 3 || first_rd !== exp_rd) begin
            mismatched++;
            $display("FAIL post_reset_idle: got rd=%0d lat=%0d, required %0d/3", rd, lat, ROM0_VAL);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, wdata, rd, exp_rd;
        logic [3:0]  bsel;
        logic        wr, er, exp_er, quiet;
        int          port, lat, we0, sel;
        for (int i = 0; i < 40; i++) begin
            port  = int'($urandom_range(0, 1));
            wr    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            bsel  = 4'($urandom_range(1, 15));
            sel   = int'($urandom_range(0, 10));
            if (sel < 7)       addr = RAM_BASE + 32'(4 * $urandom_range(0, 15));
            else if (sel == 7) addr = ($urandom_range(0, 1) != 0) ? ROM_ADDR0 : ROM_ADDR1;
            else if (sel == 8) addr = RAM_BASE + RAM_BYTES - 32'd4;
            else if (sel == 9) addr = RAM_BASE + RAM_BYTES + 32'(4 * $urandom_range(0, 3));
            else               addr = RAM_BASE - 32'd4;
            we0 = we_count;
            ref_access(wr, addr, wdata, bsel, exp_rd, exp_er);
            run_access(port, wr, addr, wdata, bsel, rd, er, lat, quiet);
            compared++;
            if (rd !== exp_rd || er !== exp_er) begin
                mismatched++;
                $display("FAIL rand%0d_data: p%0d wr=%b a=%h got rd=%h err=%b, required %h/%b",
                         i, port, wr, addr, rd, er, exp_rd, exp_er);
            end
            compared++;
            if (lat != 3 || !quiet || we_count - we0 != ((wr && !exp_er) ? 1 : 0)) begin
                mismatched++;
                $display("FAIL rand%0d_timing: got lat=%0d quiet=%b writes=%0d, required 3/1/%0d",
                         i, lat, quiet, we_count - we0, (wr && !exp_er) ? 1 : 0);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        we_count   = 0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = 32'h0;
            shadow[i] = 32'h0;
        end
        test_reset();
        test_store_load();
        test_rom_load();
        test_rom_store();
        test_illegal_load();
        test_arbitration();
        test_resp_hold_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
